// File: rtl/hash_pkg.sv
// hash_pkg: shared definitions for the hash message loader.
//   state_e              loader FSM states
//   Y_DEFAULT            default message length in bits (multiple of 8)
//   START_CYCLES_DEFAULT default width of the start strobe in cycles
package hash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_STREAM = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4
  } state_e;

  localparam int unsigned Y_DEFAULT            = 256;
  localparam int unsigned START_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/hash_msg_loader.sv
// hash_msg_loader: byte-stream front end for the Hashing core.
// Collects one message into a Y-bit buffer, serialises it MSB first with no
// gaps, strobes start, then waits for the core to report completion.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   in_data       message byte (bit 7 first on the serial side)
//   in_valid      in_data / in_last qualifier
//   in_last       final byte of the message
//   in_ready      byte accepted when in_valid & in_ready at a clock edge
//   messagexSO    serial message bit to Hashing
//   startxSO      start strobe to Hashing (START_CYCLES cycles wide)
//   hash_readyxSI completion flag from Hashing, only observed in WAIT
//   busy          high from last-byte accept until completion is seen
//
// Build option:
//   HASH_MSG_PAD_EN  append a single 1 after a short message
//
// state  | meaning
// IDLE   | clear buffer and byte count, one cycle
// FILL   | accept bytes into the buffer
// STREAM | shift buffer out one bit per clock, Y clocks
// START  | hold start strobe for START_CYCLES clocks
// WAIT   | wait for hash_readyxSI
module hash_msg_loader
  import hash_pkg::*;
#(
  parameter int unsigned Y            = Y_DEFAULT,
  parameter int unsigned START_CYCLES = START_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       messagexSO,
  output logic       startxSO,
  input  logic       hash_readyxSI,
  output logic       busy
);

  localparam int unsigned NBW = $clog2(Y/8 + 1);
  localparam int unsigned BCW = $clog2(Y + 1);
  localparam int unsigned SCW = $clog2(START_CYCLES + 1);
  localparam logic [NBW-1:0] NB_FULL = NBW'(Y/8);

  state_e           state_q, state_d;
  logic [Y-1:0]     buf_q, buf_d;
  logic [NBW-1:0]   nb_q, nb_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic             msg_q, msg_d;
  logic             start_q, start_d;

  logic [Y-1:0]     byte_vec;
  logic [NBW-1:0]   nb_inc;

  // Incoming byte parked at the top of a Y-bit word; shifting right by 8*nb
  // lands it in its slot. The buffer is cleared in IDLE, so OR-ing is enough.
  assign byte_vec = {in_data, {(Y-8){1'b0}}};
  assign nb_inc   = nb_q + NBW'(1);

`ifdef HASH_MSG_PAD_EN
  localparam logic [Y-1:0] PAD_VEC = {1'b1, {(Y-1){1'b0}}};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      nb_q    <= '0;
      bcnt_q  <= '0;
      scnt_q  <= '0;
      msg_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      nb_q    <= nb_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      msg_q   <= msg_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    nb_d    = nb_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    msg_d   = 1'b0;
    start_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        buf_d   = '0;
        nb_d    = '0;
        state_d = ST_FILL;
      end

      ST_FILL: begin
        if (in_valid) begin
          buf_d = buf_q | (byte_vec >> {nb_q, 3'b000});
`ifdef HASH_MSG_PAD_EN
          if (in_last && (nb_inc != NB_FULL)) begin
            buf_d = buf_d | (PAD_VEC >> {nb_inc, 3'b000});
          end
`endif
          nb_d = nb_inc;
          // A full buffer ends the message whatever in_last says.
          if (in_last || (nb_inc == NB_FULL)) begin
            state_d = ST_STREAM;
            bcnt_d  = BCW'(Y);
          end
        end
      end

      ST_STREAM: begin
        msg_d  = buf_q[Y-1];
        buf_d  = {buf_q[Y-2:0], 1'b0};
        bcnt_d = bcnt_q - BCW'(1);
        if (bcnt_q == BCW'(1)) begin
          state_d = ST_START;
          scnt_d  = SCW'(START_CYCLES);
        end
      end

      ST_START: begin
        start_d = 1'b1;
        scnt_d  = scnt_q - SCW'(1);
        if (scnt_q == SCW'(1)) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (hash_readyxSI) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready   = (state_q == ST_FILL);
  assign busy       = (state_q == ST_STREAM) || (state_q == ST_START) ||
                      (state_q == ST_WAIT);
  assign messagexSO = msg_q;
  assign startxSO   = start_q;

endmodule

// File: tb/tb_hash_msg_loader.sv
module tb_hash_msg_loader;

  localparam int unsigned Y  = 256;
  localparam int unsigned SC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       messagexSO;
  logic       startxSO;
  logic       hash_readyxSI;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  hash_msg_loader #(.Y(Y), .START_CYCLES(SC)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .messagexSO    (messagexSO),
    .startxSO      (startxSO),
    .hash_readyxSI (hash_readyxSI),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference bit stream: bytes MSB first, optional single-1 pad, zero fill.
  task automatic build_expected(input logic [7:0] bytes[$]);
    int nbits = 0;
    exp_q.delete();
    foreach (bytes[i]) begin
      for (int b = 7; b >= 0; b--) begin
        exp_q.push_back(bytes[i][b]);
        nbits++;
      end
    end
`ifdef HASH_MSG_PAD_EN
    if (nbits < Y) begin
      exp_q.push_back(1'b1);
      nbits++;
    end
`endif
    while (nbits < Y) begin
      exp_q.push_back(1'b0);
      nbits++;
    end
  endtask

  // Returns just after the edge that accepts the final byte.
  task automatic send_msg(input logic [7:0] bytes[$], input bit gapped, input bit hold_after,
                          input bit expect_ready_first, input bit use_last);
    int n = bytes.size();
    build_expected(bytes);
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      int gap = gapped ? int'($urandom_range(0, 2)) : 0;
      @(negedge clk);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = bytes[i];
      in_last  = use_last && (i == n - 1);
      if (i == 0 && expect_ready_first) check("ready_first", in_ready, 1);
      if (i == n - 1) check("busy_pre_last", busy, 0);
      while (!in_ready && waited < 1000) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 1000) begin
        check("accept_timeout", 0, 1);
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = hold_after;
    in_data  = hold_after ? 8'hAA : 8'h00;
    in_last  = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic check_stream(input int abort_at);
    for (int k = 0; k < int'(Y); k++) begin
      logic e;
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("exp_empty", 0, 1);
        return;
      end
      e = exp_q.pop_front();
      check($sformatf("bit%0d", k), messagexSO, e);
      if (k % 32 == 0) begin
        check("start_in_stream", startxSO, 0);
        check("busy_in_stream", busy, 1);
        check("rdy_in_stream", in_ready, 0);
      end
      if (k == abort_at) return;
    end
  endtask

  task automatic check_tail(input bit pulse_in_start, input bit hold);
    for (int i = 0; i < int'(SC); i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("start_hi%0d", i), startxSO, 1);
      check("msg_in_start", messagexSO, 0);
      check("rdy_in_start", in_ready, 0);
      if (pulse_in_start) hash_readyxSI = (i == 0);
    end
    hash_readyxSI = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("start_lo", startxSO, 0);
      check("busy_wait", busy, 1);
      check("rdy_wait", in_ready, 0);
    end
    hash_readyxSI = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hash_readyxSI = 1'b0;
    check("busy_done", busy, 0);
    check("rdy_idle", in_ready, 0);
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
      check("rdy_fill", in_ready, 1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m[$];
    int hits;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    hash_readyxSI = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_rdy", in_ready, 0);
      check("rst_start", startxSO, 0);
      check("rst_msg", messagexSO, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b1;
    #1 check("rdy_rel0", in_ready, 0);
    @(negedge clk);
    check("rdy_rel1", in_ready, 1);

    // Full message, back to back.
    m.delete();
    for (int i = 0; i < 32; i++) m.push_back(8'(i));
    send_msg(m, 0, 0, 0, 1);
    check_stream(-1);
    check_tail(1, 0);

    // Short "abc", input held valid through the busy phase.
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 0, 1, 0, 1);
    check_stream(-1);
    check_tail(0, 1);

    // Held 0xAA must not have been consumed: it heads the next message.
    m = '{8'hAA, 8'h64, 8'h65};
    send_msg(m, 0, 0, 1, 1);
    check_stream(-1);
    check_tail(0, 0);

    // Gapped full message.
    m.delete();
    for (int i = 0; i < 32; i++) m.push_back(8'(i));
    send_msg(m, 1, 0, 0, 1);
    check_stream(-1);
    check_tail(0, 0);

    // Buffer full without in_last ends the message.
    m.delete();
    for (int i = 0; i < 32; i++) m.push_back(8'($urandom));
    send_msg(m, 0, 0, 0, 0);
    check_stream(-1);
    check_tail(0, 0);

    // Reset in the middle of streaming.
    m.delete();
    for (int i = 0; i < 32; i++) m.push_back(8'($urandom));
    send_msg(m, 0, 0, 0, 1);
    check_stream(100);
    rst = 1'b0;
    #1;
    check("mid_rst_msg", messagexSO, 0);
    check("mid_rst_start", startxSO, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdy", in_ready, 0);
    exp_q.delete();
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      if (startxSO) hits++;
    end
    rst = 1'b1;
    repeat (Y + 10) begin
      @(negedge clk);
      if (startxSO) hits++;
    end
    check("no_start_after_rst", hits, 0);

    m.delete();
    for (int i = 0; i < 20; i++) m.push_back(8'($urandom));
    send_msg(m, 1, 0, 1, 1);
    check_stream(-1);
    check_tail(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
